// File: rtl/scpu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scpu_fetch_pkg
// Description : Shared types and constants for the SCPU fetch/PC stage:
//               FSM state encoding, Jump encodings, reset NOP word and
//               instruction-field slice helpers used to feed the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package scpu_fetch_pkg;

    // Fetch-stage FSM state. HALT is reachable only with FETCH_MISALIGN_TRAP_EN.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Jump control encodings driven by the decoder (2'b11 behaves as none).
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    // addi x0,x0,0 - loaded into the IR on reset so the decoder sees a NOP.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Major opcode without the always-11 low bits.
    function automatic logic [4:0] inst_opcode(input logic [31:0] inst);
        return inst[6:2];
    endfunction

    // funct3 field.
    function automatic logic [2:0] inst_fun3(input logic [31:0] inst);
        return inst[14:12];
    endfunction

    // The only funct7 bit the decoder needs (add/sub, srl/sra).
    function automatic logic inst_fun7(input logic [31:0] inst);
        return inst[30];
    endfunction

endpackage : scpu_fetch_pkg
`default_nettype wire

// File: rtl/scpu_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : scpu_next_pc
// Description : Purely combinational next-PC selection. Priority is
//               jal > jalr > taken conditional branch > sequential pc+4.
//               All additions wrap modulo 2^32.
// Revision    : 1.0 - initial release
// ============================================================================
module scpu_next_pc (
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_res,
    input  logic [1:0]  Jump,
    input  logic        Branch,
    input  logic        BranchN,
    input  logic        zero,
    output logic [31:0] next_pc
);
    import scpu_fetch_pkg::*;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus_imm;
    logic [31:0] w_jalr_target;
    logic        w_branch_taken;

    assign w_pc_plus4     = pc + 32'd4;
    assign w_pc_plus_imm  = pc + imm;
    // jalr clears bit 0 of the computed target.
    assign w_jalr_target  = alu_res & ~32'h0000_0001;
    // beq takes on zero, bne takes on not-zero.
    assign w_branch_taken = Branch && (zero ^ BranchN);

    // Select the target; the reserved Jump code falls through to branch/sequential.
    always_comb begin
        next_pc = w_pc_plus4;
        case (Jump)
            JMP_JAL:  next_pc = w_pc_plus_imm;
            JMP_JALR: next_pc = w_jalr_target;
            default: begin
                if (w_branch_taken) begin
                    next_pc = w_pc_plus_imm;
                end
            end
        endcase
    end

endmodule : scpu_next_pc
`default_nettype wire

// File: rtl/scpu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : scpu_fetch_unit
// Description : Instruction-fetch / PC stage for the single-cycle SCPU.
//               Holds PC and IR, fetches over an IMEM req/ack handshake,
//               presents decode slices and advances the PC when the
//               datapath signals ex_done.
//               Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned next PC
//               sends the FSM to HALT and raises the extra misalign output;
//               without it the low two PC bits are forced to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module scpu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = scpu_fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  Jump,
    input  logic        Branch,
    input  logic        BranchN,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [31:0] alu_res,
    input  logic        ex_done,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [4:0]  OPcode,
    output logic [2:0]  Fun3,
    output logic        Fun7
);
    import scpu_fetch_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_inst;
    logic [31:0]  w_next_pc_raw;
    logic [31:0]  w_next_pc;
    logic         w_misaligned;
    logic         w_pc_load;
    logic         w_ir_load;

    scpu_next_pc u_next_pc (
        .pc      (r_pc),
        .imm     (imm),
        .alu_res (alu_res),
        .Jump    (Jump),
        .Branch  (Branch),
        .BranchN (BranchN),
        .zero    (zero),
        .next_pc (w_next_pc_raw)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    // Keep the faulting target so software/debug can see where it went wrong.
    assign w_misaligned = (w_next_pc_raw[1:0] != 2'b00);
    assign w_next_pc    = w_next_pc_raw;
    assign misalign     = (r_state == HALT);
`else
    // Without the trap the PC is kept word aligned unconditionally.
    assign w_misaligned = 1'b0;
    assign w_next_pc    = w_next_pc_raw & ~32'h0000_0003;
`endif

    // FSM state register; reset dominates every state and input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; ack/ex_done only matter in their own state.
    always_comb begin
        w_state_next = r_state;
        w_pc_load    = 1'b0;
        w_ir_load    = 1'b0;
        imem_req     = 1'b0;
        inst_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_ir_load    = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (ex_done) begin
                    w_pc_load    = 1'b1;
                    w_state_next = w_misaligned ? HALT : FETCH;
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Program counter: advances only when the current instruction retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
        end
    end

    // Instruction register: captured on the req&&ack edge, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst <= NOP_INST;
        end else if (w_ir_load) begin
            r_inst <= imem_rdata;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = r_pc + 32'd4;
    assign inst      = r_inst;
    assign OPcode    = inst_opcode(r_inst);
    assign Fun3      = inst_fun3(r_inst);
    assign Fun7      = inst_fun7(r_inst);

endmodule : scpu_fetch_unit
`default_nettype wire
